// File: rtl/ram_access_arbiter_if.sv
// Bundle of requester handshakes and RAM-side signals for ram_access_arbiter.
// slave = arbiter side, master = requesters plus RAM model side.
interface ram_access_arbiter_if #(
    parameter int DATA_W = 48
);
    logic              wr_req;
    logic              wr_type;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic              rd_type;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ram_wren;
    logic              ram_access_type;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_q;
    logic              busy;

    modport slave (
        input  wr_req, wr_type, wr_data, rd_req, rd_type, ram_q,
        output wr_ack, rd_data, rd_valid, ram_wren, ram_access_type, ram_data_in, busy
    );

    modport master (
        output wr_req, wr_type, wr_data, rd_req, rd_type, ram_q,
        input  wr_ack, rd_data, rd_valid, ram_wren, ram_access_type, ram_data_in, busy
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Serialises transaction-writer and balance-reader accesses onto the single-port coin RAM.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on ties instead of writer-first priority.
module ram_access_arbiter #(
    parameter int READ_LAT = 2,
    parameter int DATA_W   = 48
) (
    input logic                 clock,
    input logic                 resetn,
    ram_access_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);
    localparam logic       GRANT_WR = 1'b0;
    localparam logic       GRANT_RD = 1'b1;

    logic [1:0]        state;
    logic [2:0]        lat_cnt;
    logic              last_grant;
    logic              done_from_read;
    logic              access_type_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              writer_wins;
    logic              grant_wr;
    logic              grant_rd;

`ifdef ARB_ROUND_ROBIN_EN
    assign writer_wins = (last_grant == GRANT_RD);
`else
    // Fixed priority ignores last_grant; it is still tracked so both builds share one datapath.
    assign writer_wins = 1'b1 | last_grant;
`endif

    assign grant_wr = bus.wr_req && (!bus.rd_req || writer_wins);
    assign grant_rd = bus.rd_req && !grant_wr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            lat_cnt        <= 3'd0;
            last_grant     <= GRANT_RD;
            done_from_read <= 1'b0;
            access_type_q  <= 1'b0;
            wr_data_q      <= '0;
            rd_data_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state         <= WRITE;
                        access_type_q <= bus.wr_type;
                        wr_data_q     <= bus.wr_data;
                        last_grant    <= GRANT_WR;
                        lat_cnt       <= 3'd0;
                    end else if (grant_rd) begin
                        state         <= READ;
                        access_type_q <= bus.rd_type;
                        last_grant    <= GRANT_RD;
                        lat_cnt       <= 3'd0;
                    end
                end
                WRITE: begin
                    state          <= DONE;
                    done_from_read <= 1'b0;
                end
                READ: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_cnt == LAT_LAST) begin
                        rd_data_q      <= bus.ram_q;
                        done_from_read <= 1'b1;
                        state          <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes come straight from state so a request can never glitch them.
    assign bus.ram_wren        = (state == WRITE);
    assign bus.wr_ack          = (state == WRITE);
    assign bus.rd_valid        = (state == DONE) && done_from_read;
    assign bus.busy            = (state != IDLE);
    assign bus.ram_access_type = access_type_q;
    assign bus.ram_data_in     = wr_data_q;
    assign bus.rd_data         = rd_data_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: vector table plus scoreboard of completed accesses.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN, same as the design.
module tb_ram_access_arbiter;
    localparam int READ_LAT = 2;
    localparam int DATA_W   = 48;
    localparam logic [DATA_W-1:0] RAM_IDLE_Q = 48'hBAD0_BAD0_BAD0;

    typedef struct {
        bit                is_rd;
        bit                typ;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        bit                is_rd;
        bit                typ;
        logic [DATA_W-1:0] data;
        int                exp_lat;
        int                exp_busy;
    } vec_t;

    logic              clock = 1'b0;
    logic              resetn;
    logic [DATA_W-1:0] ram_content;
    logic              busy_prev = 1'b0;
    int                read_cyc  = 0;
    int                checks    = 0;
    int                passed    = 0;
    exp_t              exp_q[$];

    always #5 clock = ~clock;

    ram_access_arbiter_if #(.DATA_W(DATA_W)) bus ();

    ram_access_arbiter #(
        .READ_LAT (READ_LAT),
        .DATA_W   (DATA_W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic int next_read_cyc();
        if (!resetn || !bus.busy || bus.ram_wren) return 0;
        if (!busy_prev) return 1;
        if (read_cyc != 0) return read_cyc + 1;
        return 0;
    endfunction

    // RAM model: q carries the stored word only in the READ_LAT-th cycle of a read access.
    always @(negedge clock) begin
        read_cyc  <= next_read_cyc();
        bus.ram_q <= (next_read_cyc() == READ_LAT) ? ram_content : RAM_IDLE_Q;
        busy_prev <= resetn ? bus.busy : 1'b0;
    end

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        int   lat;
        int   busy_n;
        bit   wren_seen;
        exp_t e;
        e = '{v.is_rd, v.typ, v.data};
        exp_q.push_back(e);
        if (v.is_rd) begin
            ram_content = v.data;
            bus.rd_type = v.typ;
            bus.rd_req  = 1'b1;
        end else begin
            bus.wr_type = v.typ;
            bus.wr_data = v.data;
            bus.wr_req  = 1'b1;
        end
        lat       = -1;
        busy_n    = 0;
        wren_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) checkOutput("access_type in first cycle", DATA_W'(bus.ram_access_type), DATA_W'(v.typ));
            if (bus.busy) busy_n++;
            if (bus.ram_wren) wren_seen = 1'b1;
            if (lat < 0 && (v.is_rd ? bus.rd_valid : bus.wr_ack)) begin
                lat        = k;
                bus.rd_req = 1'b0;
                bus.wr_req = 1'b0;
            end
            if (lat >= 0 && !bus.busy) break;
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        checkOutput(v.is_rd ? "read latency" : "write latency", DATA_W'(lat), DATA_W'(v.exp_lat));
        checkOutput("busy cycles", DATA_W'(busy_n), DATA_W'(v.exp_busy));
        checkOutput("ram_wren seen", DATA_W'(wren_seen), DATA_W'(!v.is_rd));
    endtask

    initial begin
        vec_t vecs[7];
        bit   tie_rd[4];
        int   busy_n;
        int   rd_seen;
        int   type_bad;
        int   events;
        int   n_w;
        int   n_r;

        vecs[0] = '{1'b0, 1'b1, 48'h0000_0000_00FF, 1, 2};
        vecs[1] = '{1'b1, 1'b0, 48'h1234_5678_9ABC, READ_LAT + 1, READ_LAT + 1};
        vecs[2] = '{1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 1, 2};
        vecs[3] = '{1'b1, 1'b1, 48'h8000_0000_0001, READ_LAT + 1, READ_LAT + 1};
        vecs[4] = '{1'b0, 1'b1, 48'h0000_0000_0000, 1, 2};
        vecs[5] = '{1'b1, 1'b0, 48'h0000_0000_0000, READ_LAT + 1, READ_LAT + 1};
        vecs[6] = '{1'b1, 1'b1, 48'hDEAD_BEEF_0042, READ_LAT + 1, READ_LAT + 1};
`ifdef ARB_ROUND_ROBIN_EN
        tie_rd = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        tie_rd = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        resetn      = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_type = 1'b0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;
        bus.rd_type = 1'b0;
        ram_content = '0;

        // Scoreboard monitor: every ack/valid must match the oldest expected access.
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clock);
                    if (resetn && (bus.wr_ack || bus.rd_valid)) begin
                        checkOutput("scoreboard entry available", DATA_W'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            checkOutput("scoreboard kind is read", DATA_W'(bus.rd_valid), DATA_W'(e.is_rd));
                            if (bus.rd_valid) checkOutput("rd_data", bus.rd_data, e.data);
                            else begin
                                checkOutput("ram_data_in", bus.ram_data_in, e.data);
                                checkOutput("write access_type", DATA_W'(bus.ram_access_type), DATA_W'(e.typ));
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clock);
        checkOutput("reset busy", DATA_W'(bus.busy), 0);
        checkOutput("reset wr_ack", DATA_W'(bus.wr_ack), 0);
        checkOutput("reset rd_valid", DATA_W'(bus.rd_valid), 0);
        checkOutput("reset ram_wren", DATA_W'(bus.ram_wren), 0);
        checkOutput("reset access_type", DATA_W'(bus.ram_access_type), 0);
        checkOutput("reset ram_data_in", bus.ram_data_in, 0);
        checkOutput("reset rd_data", bus.rd_data, 0);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // A read pulsed only during WRITE must never be served.
        exp_q.push_back('{1'b0, 1'b1, 48'h0000_0000_0A5A});
        bus.wr_type = 1'b1;
        bus.wr_data = 48'h0000_0000_0A5A;
        bus.wr_req  = 1'b1;
        @(negedge clock);
        checkOutput("drop: wr_ack in WRITE", DATA_W'(bus.wr_ack), 1);
        bus.wr_req  = 1'b0;
        bus.rd_type = 1'b0;
        bus.rd_req  = 1'b1;
        @(negedge clock);
        bus.rd_req = 1'b0;
        busy_n = 0; rd_seen = 0; type_bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.busy) busy_n++;
            if (bus.rd_valid) rd_seen++;
            if (bus.ram_access_type !== 1'b1) type_bad++;
            @(negedge clock);
        end
        checkOutput("drop: busy cycles after WRITE", DATA_W'(busy_n), 1);
        checkOutput("drop: rd_valid count", DATA_W'(rd_seen), 0);
        checkOutput("drop: access_type changes", DATA_W'(type_bad), 0);

        // Reset in the second READ cycle clears everything without a clock edge.
        ram_content = 48'hCAFE_F00D_1234;
        bus.rd_type = 1'b1;
        bus.rd_req  = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        checkOutput("midread: busy before reset", DATA_W'(bus.busy), 1);
        resetn     = 1'b0;
        bus.rd_req = 1'b0;
        #1;
        checkOutput("midread: busy", DATA_W'(bus.busy), 0);
        checkOutput("midread: rd_valid", DATA_W'(bus.rd_valid), 0);
        checkOutput("midread: rd_data", bus.rd_data, 0);
        @(negedge clock);
        resetn  = 1'b1;
        rd_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.rd_valid || bus.busy) rd_seen++;
        end
        checkOutput("midread: activity after release", DATA_W'(rd_seen), 0);

        // Reset during WRITE drops ram_wren immediately and issues no ack.
        bus.wr_type = 1'b1;
        bus.wr_data = 48'h0000_1111_2222;
        bus.wr_req  = 1'b1;
        @(posedge clock);
        #2;
        checkOutput("midwrite: ram_wren before reset", DATA_W'(bus.ram_wren), 1);
        resetn     = 1'b0;
        bus.wr_req = 1'b0;
        #1;
        checkOutput("midwrite: ram_wren", DATA_W'(bus.ram_wren), 0);
        checkOutput("midwrite: wr_ack", DATA_W'(bus.wr_ack), 0);
        checkOutput("midwrite: ram_data_in", bus.ram_data_in, 0);

        // Both requests held from reset; grant order comes from the scoreboard.
        bus.wr_type = 1'b1;
        bus.wr_data = 48'hAAAA_5555_0F0F;
        bus.rd_type = 1'b0;
        ram_content = 48'h0123_4567_89AB;
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        n_r = 0;
        for (int i = 0; i < 4; i++) begin
            if (tie_rd[i]) begin
                exp_q.push_back('{1'b1, 1'b0, 48'h0123_4567_89AB});
                n_r++;
            end else exp_q.push_back('{1'b0, 1'b1, 48'hAAAA_5555_0F0F});
        end
        @(negedge clock);
        resetn = 1'b1;
        events = 0; n_w = 0;
        for (int k = 0; k < 60 && events < 4; k++) begin
            @(negedge clock);
            if (bus.wr_ack) begin n_w++; events++; end
            if (bus.rd_valid) begin n_r--; events++; end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        checkOutput("tie: events within budget", DATA_W'(events), 4);
        checkOutput("tie: wr_ack count", DATA_W'(n_w), DATA_W'(4 - (tie_rd[1] + tie_rd[3])));
        checkOutput("tie: rd_valid shortfall", DATA_W'(n_r), 0);

        repeat (6) @(negedge clock);
        checkOutput("scoreboard drained", DATA_W'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
